stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
Packet-aware round-robin arbiter that shares one 8-bit valid/ready output stream between NUM_IN requester streams. It sits upstream of the registered streaming pipeline stage, so several traffic sources in a profiling bench can feed one datapath. Once a requester wins, the grant is locked until its packet's last beat is accepted, so packets are never interleaved. The block has a single registered output stage (1-cycle latency) and a max-packet-length guard.

Parameters:
NUM_IN, 4, number of requester streams (>= 2)
DATA_W, 8, data width per beat
MAX_BEATS, 16, maximum beats per packet before forced termination (>= 2)
ID_W, $clog2(NUM_IN), width of source id tag (derived, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  NUM_IN*DATA_W  requester data, slice i = requester i
in_valid  input  NUM_IN  per-requester valid
in_last  input  NUM_IN  per-requester end-of-packet flag
in_ready  output  NUM_IN  per-requester ready (combinational)
out_data  output  DATA_W  registered output data
out_valid  output  1  registered output valid
out_last  output  1  registered end-of-packet
out_id  output  ID_W  index of requester that sourced the beat
out_ready  input  1  downstream ready
trunc_err  output  1  sticky: a packet was force-terminated at MAX_BEATS

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_id=0, trunc_err=0, state=IDLE, rr_ptr=0, lock=0, beat_cnt=0. in_ready=all-zero while rst is high.
- can_load = !out_valid || out_ready. A transfer on requester i = in_valid[i] && in_ready[i].
- At most one in_ready bit is high at any time. in_ready is never high while can_load=0.
- IDLE: grant = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_IN. in_ready[grant]=can_load. No valid requester means in_ready=0.
- IDLE transfer with in_last=1: stay IDLE, rr_ptr=grant+1 (wrap).
- IDLE transfer with in_last=0: go to BUSY, lock=grant, beat_cnt=1.
- BUSY: in_ready[lock]=can_load; all other in_ready bits are 0. Other requesters' valids are ignored.
- BUSY transfer: beat_cnt++.
  - If in_last=1: go to IDLE, rr_ptr=lock+1.
  - Else if beat_cnt+1 == MAX_BEATS: this beat is emitted with out_last forced to 1, trunc_err set to 1, go to IDLE, rr_ptr=lock+1. Remaining beats of that source then arbitrate as a new packet.
- Output register: on any transfer, out_data/out_last/out_id/out_valid=1 load next cycle (latency 1). Otherwise, if out_ready then out_valid=0 and data/last/id hold their last value. Full throughput: a beat accepted every cycle when out_ready is held high.
- out_valid, once high, stays high with data/last/id stable until out_ready.
- Requester deasserting in_valid mid-packet in BUSY: the lock holds and no other source is granted (no timeout on bubbles).
- A single-beat packet (in_last on the first beat) never enters BUSY.
- trunc_err is cleared only by rst.
- Reset mid-packet: the partial packet is dropped, the lock is released, and rr_ptr returns to 0.

Test Plan:
- Single source: req0 sends 3-beat packet A0,A1,A2(last) with out_ready=1 -> out stream A0,A1,A2 on consecutive cycles starting 1 cycle later, out_id=0, out_last only on A2.
- Round-robin fairness: all 4 requesters hold valid with single-beat packets 0x10,0x20,0x30,0x40 repeated -> output id order 0,1,2,3,0,1,... with no source granted twice in a row.
- Packet lock: req1 mid 4-beat packet while req0 and req2 raise valid -> req1 beats are contiguous, then req2 is granted (rr_ptr=2), then req0.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> out_valid/out_data stable, all in_ready=0, no beat lost or duplicated when out_ready returns.
- Truncation: MAX_BEATS=16, req3 sends 20 beats with no last -> 16th beat has out_last=1, trunc_err=1 from the next cycle. Beats 17-20 then appear as a new packet after round-robin arbitration.
- Async reset mid-packet: assert rst between clock edges during BUSY -> out_valid=0 immediately, in_ready=0. After release, req0 wins first (rr_ptr=0).

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//   Packet-aware round-robin arbiter that merges NUM_IN valid/ready requester
//   streams into one registered output stream. A requester that starts a
//   multi-beat packet keeps the grant until its last beat is taken, so packets
//   are never interleaved. Packets reaching MAX_BEATS beats are cut with a
//   forced out_last and flagged on the sticky trunc_err.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous, active-high reset
//   in_data    requester data, slice i = requester i
//   in_valid   per-requester valid
//   in_last    per-requester end-of-packet flag
//   in_ready   per-requester ready (combinational, at most one bit high)
//   out_data   registered output data
//   out_valid  registered output valid
//   out_last   registered end-of-packet
//   out_id     index of the requester that sourced the output beat
//   out_ready  downstream ready
//   trunc_err  sticky: a packet was force-terminated at MAX_BEATS
module stream_rr_arbiter #(
  parameter  int unsigned NUM_IN    = 4,
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned MAX_BEATS = 16,
  localparam int unsigned ID_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_last,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready,
  output logic                     trunc_err
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   lock;
  logic [CNT_W-1:0]  beat_cnt;

  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   sel;
  logic              any_valid;
  logic              sel_req;
  logic              can_load;
  logic              xfer;
  logic              sel_last;
  logic              trunc;
  logic [DATA_W-1:0] sel_data;
  int unsigned       idx;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
    return (32'(p) == NUM_IN - 1) ? '0 : p + ID_W'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_IN.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_IN;
      if (!any_valid && in_valid[idx]) begin
        any_valid = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

  // While locked, the owner is the only candidate even if it bubbles.
  always_comb begin
    sel      = (state == BUSY) ? lock : grant;
    sel_req  = (state == BUSY) || any_valid;
    can_load = !out_valid || out_ready;
    in_ready = '0;
    if (!rst && sel_req && can_load) in_ready[sel] = 1'b1;
    xfer     = in_valid[sel] && in_ready[sel];
    sel_data = in_data[32'(sel)*DATA_W +: DATA_W];
    sel_last = in_last[sel];
    // beat_cnt counts beats already taken in this packet, so the current
    // beat is number beat_cnt+1.
    trunc    = (state == BUSY) && !sel_last && (32'(beat_cnt) + 1 == MAX_BEATS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_id    <= '0;
      trunc_err <= 1'b0;
      state     <= IDLE;
      rr_ptr    <= '0;
      lock      <= '0;
      beat_cnt  <= '0;
    end else begin
      if (xfer) begin
        out_data  <= sel_data;
        out_last  <= sel_last || trunc;
        out_id    <= sel;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (xfer) begin
        if (state == IDLE) begin
          if (sel_last) begin
            rr_ptr <= wrap_inc(sel);
          end else begin
            state    <= BUSY;
            lock     <= sel;
            beat_cnt <= CNT_W'(1);
          end
        end else if (sel_last || trunc) begin
          state    <= IDLE;
          rr_ptr   <= wrap_inc(lock);
          beat_cnt <= '0;
          if (trunc) trunc_err <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a packet-level reference model.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic [IW-1:0]   out_id;
  logic            out_ready;
  logic            trunc_err;

  int errors = 0;
  int checks = 0;

  // Per-source pending beats {last, data}; accepted output beats {id, last, data}.
  logic [8:0]  srcq [N][$];
  logic [10:0] outq [$];

  // Reference model state: owner of an open packet (-1 = none), round-robin
  // start point, beats taken so far in the open packet, and expected outputs.
  int         owner, ptr, cnt, exp_g;
  bit         xfer;
  logic [N-1:0] exp_ready;
  logic       exp_valid, exp_last, exp_trunc;
  logic [7:0] exp_data;
  logic [1:0] exp_id;

  stream_rr_arbiter #(.NUM_IN(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_id(out_id),
    .out_ready(out_ready), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    owner = -1; ptr = 0; cnt = 0;
    exp_valid = 0; exp_last = 0; exp_data = '0; exp_id = '0; exp_trunc = 0;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 0;
    return !exp_valid;
  endfunction

  // Drive inputs just after the falling edge and predict who may send.
  task automatic drive(input int vp, input int rp);
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && int'($urandom_range(99)) < vp) begin
        in_valid[i] = 1'b1;
        in_data[i*DW +: DW] = srcq[i][0][7:0];
        in_last[i] = srcq[i][0][8];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*DW +: DW] = 8'($urandom);
        in_last[i] = 1'($urandom);
      end
    end
    out_ready = (int'($urandom_range(99)) < rp);
    exp_g = -1;
    if (owner >= 0) exp_g = owner;
    else for (int k = 0; k < N; k++)
      if (exp_g < 0 && in_valid[(ptr + k) % N]) exp_g = (ptr + k) % N;
    exp_ready = '0;
    xfer = 0;
    if (exp_g >= 0 && (!exp_valid || out_ready)) begin
      exp_ready[exp_g] = 1'b1;
      xfer = in_valid[exp_g];
    end
    #1;
  endtask

  // Record the DUT's accepted beat, cross the rising edge, update the model.
  task automatic advance();
    int len;
    bit fin, forced;
    if (out_valid && out_ready) outq.push_back({out_id, out_last, out_data});
    @(posedge clk);
    if (xfer) begin
      len    = (owner < 0) ? 1 : cnt + 1;
      forced = !in_last[exp_g] && (len == MB);
      fin    = in_last[exp_g] || forced;
      exp_valid = 1; exp_data = in_data[exp_g*DW +: DW];
      exp_last = fin; exp_id = 2'(exp_g);
      if (forced) exp_trunc = 1;
      if (fin) begin owner = -1; ptr = (exp_g + 1) % N; end
      else begin owner = exp_g; cnt = len; end
      void'(srcq[exp_g].pop_front());
    end else if (out_ready) begin
      exp_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input int vp, input int rp, input bit drain);
    int c = 0;
    while (c < n && !(drain && drained())) begin
      drive(vp, rp);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, exp_ready);
      end
      checks++;
      if ({out_valid, out_last, out_id, out_data} !== {exp_valid, exp_last, exp_id, exp_data}) begin
        errors++;
        $display("FAIL out_beat t=%0t got v%b l%b id%0d d%h exp v%b l%b id%0d d%h", $time,
                 out_valid, out_last, out_id, out_data, exp_valid, exp_last, exp_id, exp_data);
      end
      checks++;
      if (trunc_err !== exp_trunc) begin
        errors++;
        $display("FAIL trunc_err t=%0t got %b exp %b", $time, trunc_err, exp_trunc);
      end
      advance();
      c++;
    end
    if (drain) begin
      checks++;
      if (!drained()) begin
        errors++;
        $display("FAIL drain_timeout t=%0t got pending exp drained", $time);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    outq.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    #2 rst = 1'b1;
    in_valid = '1;
    #2;
    checks++;
    if (in_ready !== '0) begin
      errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_last, out_id, out_data, trunc_err} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {out_valid, out_last, out_id, out_data, trunc_err});
    end
    checks++;
    if (in_ready !== '0) begin
      errors++; $display("FAIL reset_in_ready2 got %b exp 0000", in_ready);
    end
    do_reset();
  endtask

  task automatic test_single_source();
    logic [10:0] e [3];
    e = '{{2'd0, 1'b0, 8'hA0}, {2'd0, 1'b0, 8'hA1}, {2'd0, 1'b1, 8'hA2}};
    do_reset();
    srcq[0].push_back({1'b0, 8'hA0});
    srcq[0].push_back({1'b0, 8'hA1});
    srcq[0].push_back({1'b1, 8'hA2});
    run(10, 100, 100, 1);
    checks++;
    if (outq.size() != 3) begin
      errors++; $display("FAIL single_count got %0d exp 3", outq.size());
    end else for (int k = 0; k < 3; k++) begin
      checks++;
      if (outq[k] !== e[k]) begin
        errors++; $display("FAIL single_beat%0d got %h exp %h", k, outq[k], e[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [10:0] exp;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 8'(16 * (i + 1))});
    run(40, 100, 100, 1);
    checks++;
    if (outq.size() != 12) begin
      errors++; $display("FAIL rr_count got %0d exp 12", outq.size());
    end else for (int k = 0; k < 12; k++) begin
      exp = {2'(k % N), 1'b1, 8'(16 * (k % N + 1))};
      checks++;
      if (outq[k] !== exp) begin
        errors++; $display("FAIL rr_order%0d got %h exp %h", k, outq[k], exp);
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [10:0] e [6];
    e = '{{2'd1, 1'b0, 8'h51}, {2'd1, 1'b0, 8'h52}, {2'd1, 1'b0, 8'h53},
          {2'd1, 1'b1, 8'h54}, {2'd2, 1'b1, 8'h02}, {2'd0, 1'b1, 8'h01}};
    do_reset();
    for (int b = 0; b < 4; b++) srcq[1].push_back({b == 3, 8'(8'h51 + b)});
    run(1, 100, 100, 0);
    srcq[0].push_back({1'b1, 8'h01});
    srcq[2].push_back({1'b1, 8'h02});
    run(30, 100, 100, 1);
    checks++;
    if (outq.size() != 6) begin
      errors++; $display("FAIL lock_count got %0d exp 6", outq.size());
    end else for (int k = 0; k < 6; k++) begin
      checks++;
      if (outq[k] !== e[k]) begin
        errors++; $display("FAIL lock_order%0d got %h exp %h", k, outq[k], e[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] exp;
    do_reset();
    for (int b = 0; b < 4; b++) srcq[0].push_back({b == 3, 8'(8'hB0 + b)});
    run(2, 100, 100, 0);
    run(5, 100, 0, 0);
    checks++;
    if (in_ready !== '0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall got ready=%b valid=%b exp ready=0000 valid=1", in_ready, out_valid);
    end
    run(20, 100, 100, 1);
    checks++;
    if (outq.size() != 4) begin
      errors++; $display("FAIL bp_count got %0d exp 4", outq.size());
    end else for (int k = 0; k < 4; k++) begin
      exp = {2'd0, k == 3, 8'(8'hB0 + k)};
      checks++;
      if (outq[k] !== exp) begin
        errors++; $display("FAIL bp_beat%0d got %h exp %h", k, outq[k], exp);
      end
    end
  endtask

  task automatic test_truncation();
    logic [10:0] exp;
    do_reset();
    for (int b = 0; b < 20; b++) srcq[3].push_back({1'b0, 8'(b + 1)});
    run(3, 100, 100, 0);
    srcq[0].push_back({1'b1, 8'hEE});
    run(60, 100, 100, 1);
    checks++;
    if (outq.size() != 21) begin
      errors++; $display("FAIL trunc_count got %0d exp 21", outq.size());
    end else for (int k = 0; k < 21; k++) begin
      if (k < 16)       exp = {2'd3, k == 15, 8'(k + 1)};
      else if (k == 16) exp = {2'd0, 1'b1, 8'hEE};
      else              exp = {2'd3, 1'b0, 8'(k)};
      checks++;
      if (outq[k] !== exp) begin
        errors++; $display("FAIL trunc_beat%0d got %h exp %h", k, outq[k], exp);
      end
    end
    checks++;
    if (trunc_err !== 1'b1) begin
      errors++; $display("FAIL trunc_sticky got %b exp 1", trunc_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    srcq[1].push_back({1'b1, 8'h11});
    for (int b = 0; b < 6; b++) srcq[2].push_back({b == 5, 8'(8'h21 + b)});
    run(3, 100, 100, 0);
    drive(100, 100);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== '0) begin
      errors++; $display("FAIL async_rst got valid=%b ready=%b exp valid=0 ready=0000", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) srcq[i].delete();
    outq.delete();
    model_reset();
    rst = 1'b0;
    srcq[0].push_back({1'b1, 8'h0A});
    srcq[3].push_back({1'b1, 8'h0D});
    run(10, 100, 100, 1);
    checks++;
    if (outq.size() != 2 || outq[0] !== {2'd0, 1'b1, 8'h0A} || outq[1] !== {2'd3, 1'b1, 8'h0D}) begin
      errors++; $display("FAIL async_rst_order got n=%0d first=%h exp n=2 first=%h", outq.size(),
                         (outq.size() > 0) ? outq[0] : 11'h0, {2'd0, 1'b1, 8'h0A});
    end
  endtask

  task automatic test_random();
    int total = 0;
    int len;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 8; p++) begin
        len = ($urandom_range(9) == 0) ? 18 : int'($urandom_range(5, 1));
        for (int b = 0; b < len; b++) srcq[i].push_back({b == len - 1, 8'($urandom)});
        total += len;
      end
    run(6000, 70, 70, 1);
    checks++;
    if (outq.size() != total) begin
      errors++; $display("FAIL random_count got %0d exp %0d", outq.size(), total);
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_truncation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
